// File: rtl/clk_reg_pkg.sv
// rtl/clk_reg_pkg.sv - CLK register field positions, encodings and sequencer states
package clk_reg_pkg;

  localparam int BIT_RESET  = 7;
  localparam int BIT_PLLENA = 6;
  localparam int BIT_OSCENA = 5;
  localparam int OSCM_MSB   = 4;
  localparam int OSCM_LSB   = 3;
  localparam int CLKSEL_MSB = 2;
  localparam int CLKSEL_LSB = 0;

  typedef enum logic [2:0] {
    CLKSEL_RCFAST = 3'd0,
    CLKSEL_RCSLOW = 3'd1,
    CLKSEL_XINPUT = 3'd2,
    CLKSEL_XTAL1  = 3'd3,
    CLKSEL_PLL2X  = 3'd4,
    CLKSEL_PLL4X  = 3'd5,
    CLKSEL_PLL8X  = 3'd6,
    CLKSEL_PLL16X = 3'd7
  } clksel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENABLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SWITCH = 3'd3,
    ST_RESREQ = 3'd4
  } state_e;

  localparam logic [7:0] CFG_RESET = 8'h00;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter that parks at zero
module settle_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             nres,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!nres) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/clkset_ctl.sv
// rtl/clkset_ctl.sv - CLKSET write sequencer feeding the clock divider cfg bus
module clkset_ctl
  import clk_reg_pkg::*;
#(
  parameter int OSC_WAIT  = 1600000,
  parameter int PLL_WAIT  = 16000,
  parameter int RES_PULSE = 16,
  parameter int CNT_W     = 21
) (
  input  logic       clk,
  input  logic       nres,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] cfg,
  output logic       busy,
  output logic       sw_res
);

  localparam int MAX_WAIT = (OSC_WAIT > PLL_WAIT) ? OSC_WAIT : PLL_WAIT;
  localparam int RES_W    = $clog2(RES_PULSE) + 1;

  state_e           state_q;
  logic [6:0]       cfg_q;
  logic [6:0]       target_q;
  logic [6:0]       pend_q;
  logic             pend_vld_q;
  logic             sw_res_q;
  logic [CNT_W-1:0] wait_q;
  logic [RES_W-1:0] res_cnt_q;

  logic             wr_cfg;
  logic             wr_rst;
  logic             cand_vld;
  logic [6:0]       cand;
  logic             osc_up;
  logic             pll_up;
  logic             decide;
  logic             timer_done;
  logic [CNT_W-1:0] wait_d;

  assign wr_cfg = wr & ~wdata[BIT_RESET];
  assign wr_rst = wr & wdata[BIT_RESET];

  // The newest write always wins, whether it arrives now or was parked earlier.
  assign cand_vld = wr_cfg | pend_vld_q;
  assign cand     = wr_cfg ? wdata[6:0] : pend_q;
  assign osc_up   = cand[BIT_OSCENA] & ~cfg_q[BIT_OSCENA];
  assign pll_up   = cand[BIT_PLLENA] & ~cfg_q[BIT_PLLENA];
  assign decide   = (state_q == ST_IDLE) || (state_q == ST_SWITCH);

  always_comb begin
    wait_d = CNT_W'(PLL_WAIT);
    if (osc_up && pll_up) begin
      wait_d = CNT_W'(MAX_WAIT);
    end else if (osc_up) begin
      wait_d = CNT_W'(OSC_WAIT);
    end
  end

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk   (clk),
    .nres  (nres),
    .load  (state_q == ST_ENABLE),
    .value (wait_q),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!nres) begin
      state_q    <= ST_IDLE;
      cfg_q      <= CFG_RESET[6:0];
      target_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      wait_q     <= '0;
      res_cnt_q  <= '0;
      sw_res_q   <= 1'b0;
    end else if (wr_rst) begin
      state_q    <= ST_RESREQ;
      cfg_q      <= CFG_RESET[6:0];
      pend_vld_q <= 1'b0;
      sw_res_q   <= 1'b1;
      res_cnt_q  <= RES_W'(RES_PULSE - 1);
    end else begin
      case (state_q)
        ST_IDLE, ST_SWITCH: begin
          if (cand_vld) begin
            pend_vld_q <= 1'b0;
            target_q   <= cand;
            // Raise enables now but keep the old CLKSEL until the source settles.
            if (osc_up || pll_up) begin
              cfg_q   <= {cand[BIT_PLLENA:OSCM_LSB], cfg_q[CLKSEL_MSB:CLKSEL_LSB]};
              wait_q  <= wait_d;
              state_q <= ST_ENABLE;
            end else begin
              cfg_q   <= cand;
              state_q <= ST_SWITCH;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ENABLE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (timer_done) begin
            cfg_q   <= target_q;
            state_q <= ST_SWITCH;
          end
        end
        ST_RESREQ: begin
          if (res_cnt_q == '0) begin
            sw_res_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            res_cnt_q <= res_cnt_q - RES_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (wr_cfg && !decide) begin
        pend_q     <= wdata[6:0];
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign cfg    = {1'b0, cfg_q};
  assign busy   = (state_q != ST_IDLE) | pend_vld_q;
  assign sw_res = sw_res_q;

endmodule
